accel_sample_sched: RTL and testbench
=====================================

// Module: accel_sample_sched
// PURPOSE
//  Periodic sample scheduler feeding speed_calc. Every SAMPLE_DIV clocks it reads X then Y from the
//  accelerometer read port with a req/ack handshake. It latches both 12-bit raw samples and presents
//  them as one coherent pair with a 1-cycle sample_valid pulse. It detects read timeouts and tick
//  overruns, so speed_calc never sees a half-updated X/Y pair.
// PARAMETERS
//  DATA_W      12      raw accelerometer sample width (sign-magnitude as delivered by the sensor)
//  SAMPLE_DIV  100000  clocks between sample ticks; must be >= 2
//  TIMEOUT     1024    max clocks rd_req may stay high without rd_ack; must be >= 2
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous, active-high reset
//  enable        in   1       1 = run periodic sampling
//  rd_req        out  1       read request to sensor interface; held high until acked
//  rd_axis       out  1       axis being read: 0 = X, 1 = Y; stable while rd_req high
//  rd_ack        in   1       1-cycle acknowledge; rd_data valid in the same cycle
//  rd_data       in   DATA_W  sample returned with rd_ack
//  x_acc         out  DATA_W  latched X sample to speed_calc
//  y_acc         out  DATA_W  latched Y sample to speed_calc
//  sample_valid  out  1       1-cycle pulse: x_acc/y_acc updated as a pair this cycle
//  busy          out  1       1 whenever the FSM is not IDLE or WAIT_TICK
//  timeout_err   out  1       sticky; set on any read timeout
//  overrun_cnt   out  8       saturating count of ticks that arrived while busy
//  err_clr       in   1       synchronous clear of timeout_err and overrun_cnt
// BEHAVIOUR
//  Reset (async, any time, including mid-transaction):
//   - state = IDLE; all outputs 0; tick counter 0; shadow X register 0.
//  Tick generator:
//   - Counts 0..SAMPLE_DIV-1 while enable=1, then wraps; tick pulses for one cycle at wrap.
//   - Counter is held at 0 while enable=0.
//  FSM states: IDLE, WAIT_TICK, REQ_X, REQ_Y, PUBLISH.
//   - IDLE -> WAIT_TICK when enable=1.
//   - WAIT_TICK -> REQ_X on tick. Goes -> IDLE if enable=0 and no tick is pending.
//   - REQ_X: rd_req=1, rd_axis=0.
//     - On rd_ack: capture rd_data into the shadow X register, then -> REQ_Y.
//     - rd_req is low for at least 1 cycle between the two reads.
//   - REQ_Y: rd_req=1, rd_axis=1. On rd_ack -> PUBLISH, with rd_data latched as y_next.
//   - PUBLISH (1 cycle): x_acc <= shadow X; y_acc <= y_next; sample_valid=1; then -> WAIT_TICK.
//  Handshake rules:
//   - rd_ack is honoured only while rd_req=1; a stray rd_ack is ignored.
//   - rd_req falls in the cycle after the ack.
//  Latency: with the ack arriving N cycles after rd_req rises, tick -> sample_valid = 2N+4 clocks.
//  Timeout:
//   - A wait counter resets on entry to each REQ state.
//   - If it reaches TIMEOUT-1 with no ack: rd_req drops, timeout_err is set, and the FSM goes
//     -> WAIT_TICK.
//   - No publish occurs; x_acc/y_acc keep their previous pair, and the shadow X is discarded.
//  Overrun: a tick in any busy state increments overrun_cnt (saturates at 255). That tick is dropped.
//  enable falling mid-transaction: the current pair completes (or times out), then the FSM returns
//   to IDLE.
//  err_clr with a simultaneous error event: the event wins (the flag stays set / the count becomes 1).
//  Data is passed through unmodified; two's-complement conversion stays in speed_calc.
// STRUCTURE
//  Shared package/header accel_pkg:
//   - state encodings (3-bit localparams)
//   - AXIS_X = 1'b0, AXIS_Y = 1'b1
//   - DATA_W default
//  Sub-module accel_tick_gen:
//   - parameter SAMPLE_DIV; ports clk, rst, enable, tick.
//  Everything else is inline: FSM, wait counter, shadow/output registers.
// TESTING (bench: SAMPLE_DIV=20, TIMEOUT=8, sensor model acks 2 cycles after rd_req rises)
//  1. Reset, then enable=1; model returns X=12'h9C2, Y=12'h9C7 ->
//     x_acc=12'h9C2 and y_acc=12'h9C7 with exactly one sample_valid, 8 clocks after tick;
//     rd_axis is 0 then 1.
//  2. Model never acks Y -> timeout_err=1 eight cycles after the Y rd_req;
//     x_acc/y_acc keep the prior pair; no sample_valid. The next tick then succeeds normally.
//  3. Ack delay 15 with SAMPLE_DIV=20 -> overrun_cnt increments once per tick landing in a busy
//     state. err_clr returns it to 0.
//  4. Pulse rd_ack while rd_req=0 -> no state change, no capture.
//  5. Assert rst while in REQ_Y -> all outputs 0 in the same cycle.
//     After release with enable=1, the first sample_valid occurs only after a full SAMPLE_DIV tick.
//  6. Drop enable during REQ_X -> the pair completes, one sample_valid, FSM reaches IDLE;
//     rd_req stays 0 thereafter.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer sample scheduler: FSM encodings, axis codes, widths.
package accel_pkg;

    localparam int DATA_W_DEF = 12;

    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_REQ_X     = 3'd2,
        ST_REQ_Y     = 3'd3,
        ST_PUBLISH   = 3'd4
    } state_t;

endpackage

// File: rtl/accel_tick_gen.sv
// Free-running sample tick: one-cycle pulse every SAMPLE_DIV enabled clocks, parked at 0 when disabled.
module accel_tick_gen #(
    parameter int SAMPLE_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_wrap;

    assign at_wrap = (cnt == CNT_W'(SAMPLE_DIV - 1));
    assign tick    = enable && at_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!enable || at_wrap)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/accel_sample_sched.sv
// Periodic X-then-Y accelerometer reader; publishes each coherent X/Y pair with a one-cycle pulse.
module accel_sample_sched
    import accel_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SAMPLE_DIV = 100000,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              rd_req,
    output logic              rd_axis,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] x_acc,
    output logic [DATA_W-1:0] y_acc,
    output logic              sample_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        overrun_cnt,
    input  logic              err_clr
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              state, state_nxt;
    logic                tick;
    logic                ack_ok;
    logic                wait_expired;
    logic                overrun_evt;
    logic [WCNT_W-1:0]   wcnt;
    logic [DATA_W-1:0]   shadow_x;

    accel_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign ack_ok       = rd_req && rd_ack;
    assign wait_expired = rd_req && !rd_ack && (wcnt == WCNT_W'(TIMEOUT - 1));
    assign busy         = (state == ST_REQ_X) || (state == ST_REQ_Y) || (state == ST_PUBLISH);
    assign overrun_evt  = tick && busy;
    assign sample_valid = (state == ST_PUBLISH);
    assign rd_axis      = (state == ST_REQ_Y) ? AXIS_Y : AXIS_X;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (enable) state_nxt = ST_WAIT_TICK;
            ST_WAIT_TICK: if (tick) state_nxt = ST_REQ_X;
                          else if (!enable) state_nxt = ST_IDLE;
            ST_REQ_X:     if (ack_ok) state_nxt = ST_REQ_Y;
                          else if (wait_expired) state_nxt = ST_WAIT_TICK;
            ST_REQ_Y:     if (ack_ok) state_nxt = ST_PUBLISH;
                          else if (wait_expired) state_nxt = ST_WAIT_TICK;
            ST_PUBLISH:   state_nxt = ST_WAIT_TICK;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // REQ_Y is entered with rd_req low for one cycle, giving the mandatory gap between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rd_req <= 1'b0;
            wcnt   <= '0;
        end else begin
            state  <= state_nxt;
            rd_req <= (state_nxt == ST_REQ_X) ||
                      (state_nxt == ST_REQ_Y && state == ST_REQ_Y);
            wcnt   <= rd_req ? wcnt + WCNT_W'(1) : '0;
        end
    end

    // The pair is committed on the Y ack edge so it is already stable during the publish pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_x <= '0;
            x_acc    <= '0;
            y_acc    <= '0;
        end else begin
            if (state == ST_REQ_X && ack_ok)
                shadow_x <= rd_data;
            if (state == ST_REQ_Y && ack_ok) begin
                x_acc <= shadow_x;
                y_acc <= rd_data;
            end
        end
    end

    // Error events take priority over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (wait_expired)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;

            if (overrun_evt)
                overrun_cnt <= err_clr ? 8'd1 :
                               (overrun_cnt == 8'hFF) ? overrun_cnt : overrun_cnt + 8'd1;
            else if (err_clr)
                overrun_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_accel_sample_sched.sv
// Bench for accel_sample_sched: two instances (short and long timeout) with behavioural sensors and a timeline model.
module tb_accel_sample_sched;

    localparam int DW    = 12;
    localparam int DIV   = 20;
    localparam int TO0   = 8;
    localparam int TO1   = 32;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst, enable, err_clr;
    logic          rd_req[2], rd_axis[2], rd_ack[2], sample_valid[2], busy[2], timeout_err[2];
    logic [DW-1:0] rd_data[2], x_acc[2], y_acc[2];
    logic [7:0]    overrun_cnt[2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // sensor configuration
    int            dly_x[2], dly_y[2];
    logic [DW-1:0] xv[2], yv[2];
    logic          stray[2];

    // timeline model
    int            tcnt;
    int            busy_s[2], busy_e[2], xr_s[2], xr_e[2], yr_s[2], yr_e[2];
    int            pub_at[2], err_at[2], movr[2];
    logic [DW-1:0] px[2], py[2], mx[2], my[2];
    logic          merr[2];

    accel_sample_sched #(.DATA_W(DW), .SAMPLE_DIV(DIV), .TIMEOUT(TO0)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .rd_req(rd_req[0]), .rd_axis(rd_axis[0]), .rd_ack(rd_ack[0]), .rd_data(rd_data[0]),
        .x_acc(x_acc[0]), .y_acc(y_acc[0]), .sample_valid(sample_valid[0]), .busy(busy[0]),
        .timeout_err(timeout_err[0]), .overrun_cnt(overrun_cnt[0]), .err_clr(err_clr)
    );

    accel_sample_sched #(.DATA_W(DW), .SAMPLE_DIV(DIV), .TIMEOUT(TO1)) u_ovr (
        .clk(clk), .rst(rst), .enable(enable),
        .rd_req(rd_req[1]), .rd_axis(rd_axis[1]), .rd_ack(rd_ack[1]), .rd_data(rd_data[1]),
        .x_acc(x_acc[1]), .y_acc(y_acc[1]), .sample_valid(sample_valid[1]), .busy(busy[1]),
        .timeout_err(timeout_err[1]), .overrun_cnt(overrun_cnt[1]), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d cyc %0d: got %0h expected %0h", name, c, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        tcnt = 0;
        for (int c = 0; c < 2; c++) begin
            busy_s[c] = 0; busy_e[c] = -1; xr_s[c] = 0; xr_e[c] = -1; yr_s[c] = 0; yr_e[c] = -1;
            pub_at[c] = -1; err_at[c] = -1; movr[c] = 0; merr[c] = 1'b0;
            mx[c] = '0; my[c] = '0; px[c] = '0; py[c] = '0;
        end
    endtask

    // Lay out one transaction started by a tick seen in cycle t.
    task automatic start_txn(input int c, input int t);
        int to, dx, dy, r;
        to = (c == 0) ? TO0 : TO1;
        dx = dly_x[c];
        dy = dly_y[c];
        busy_s[c] = t + 1; xr_s[c] = t + 1;
        yr_s[c] = 0; yr_e[c] = -1; pub_at[c] = -1; err_at[c] = -1;
        if (dx >= to) begin
            xr_e[c] = t + to; busy_e[c] = t + to; err_at[c] = t + to + 1;
        end else begin
            xr_e[c] = t + 1 + dx;
            r = t + dx + 3;
            yr_s[c] = r;
            if (dy >= to) begin
                yr_e[c] = r + to - 1; busy_e[c] = r + to - 1; err_at[c] = r + to;
            end else begin
                yr_e[c] = r + dy; pub_at[c] = t + dx + dy + 4; busy_e[c] = pub_at[c];
                px[c] = xv[c]; py[c] = yv[c];
            end
        end
    endtask

    // Sensor: acks N cycles after rd_req rises; a stray ack can be injected at any time.
    initial begin
        int hi[2];
        int dl;
        hi[0] = 0; hi[1] = 0;
        rd_ack[0] = 1'b0; rd_ack[1] = 1'b0; rd_data[0] = '0; rd_data[1] = '0;
        forever begin
            @(posedge clk); #1;
            for (int c = 0; c < 2; c++) begin
                hi[c] = (rd_req[c] === 1'b1) ? hi[c] + 1 : 0;
                dl = (rd_axis[c] === 1'b1) ? dly_y[c] : dly_x[c];
                rd_ack[c]  = stray[c] || (rd_req[c] === 1'b1 && hi[c] == dl + 1);
                rd_data[c] = stray[c] ? 12'hFFF : ((rd_axis[c] === 1'b1) ? yv[c] : xv[c]);
            end
        end
    end

    // Every cycle: compare both instances to the model, then advance it with the inputs for the next edge.
    initial begin
        logic tick, was_busy;
        int   nxt;
        model_reset();
        forever begin
            @(posedge clk); #7;
            if (rst) model_reset();
            for (int c = 0; c < 2; c++) begin
                logic in_x, in_y;
                in_x = (cyc >= xr_s[c] && cyc <= xr_e[c]);
                in_y = (cyc >= yr_s[c] && cyc <= yr_e[c]);
                chk("sample_valid", c, sample_valid[c], cyc == pub_at[c]);
                chk("x_acc", c, x_acc[c], mx[c]);
                chk("y_acc", c, y_acc[c], my[c]);
                chk("busy", c, busy[c], cyc >= busy_s[c] && cyc <= busy_e[c]);
                chk("rd_req", c, rd_req[c], in_x || in_y);
                if (in_x || in_y) chk("rd_axis", c, rd_axis[c], in_y);
                chk("timeout_err", c, timeout_err[c], merr[c]);
                chk("overrun_cnt", c, overrun_cnt[c], movr[c]);
            end
            if (!rst) begin
                tick = enable && (tcnt == DIV - 1);
                tcnt = enable ? (tcnt + 1) % DIV : 0;
                nxt  = cyc + 1;
                for (int c = 0; c < 2; c++) begin
                    was_busy = (cyc >= busy_s[c] && cyc <= busy_e[c]);
                    if (tick && !was_busy) start_txn(c, cyc);
                    if (nxt == err_at[c]) merr[c] = 1'b1;
                    else if (err_clr) merr[c] = 1'b0;
                    if (tick && was_busy) movr[c] = err_clr ? 1 : ((movr[c] < 255) ? movr[c] + 1 : 255);
                    else if (err_clr) movr[c] = 0;
                    if (nxt == pub_at[c]) begin mx[c] = px[c]; my[c] = py[c]; end
                end
            end
        end
    end

    task automatic at(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed scenario with hand-computed cycle numbers (enable rises at cycle 5 -> first tick in cycle 24).
    initial begin
        rst = 1'b1; enable = 1'b0; err_clr = 1'b0;
        stray[0] = 1'b0; stray[1] = 1'b0;
        dly_x[0] = 2;  dly_y[0] = 2;  xv[0] = 12'h9C2; yv[0] = 12'h9C7;
        dly_x[1] = 15; dly_y[1] = 15; xv[1] = 12'h123; yv[1] = 12'h456;

        at(2);
        chk("rst_x", 0, x_acc[0], 0);   chk("rst_req", 0, rd_req[0], 0);
        chk("rst_busy", 0, busy[0], 0); chk("rst_ovr", 0, overrun_cnt[0], 0);
        at(3); rst = 1'b0;
        at(5); enable = 1'b1;

        // first pair: tick 24 -> publish 32
        at(31); chk("t1_sv_before", 0, sample_valid[0], 0);
        at(32); chk("t1_sv", 0, sample_valid[0], 1);
                chk("t1_x", 0, x_acc[0], 12'h9C2); chk("t1_y", 0, y_acc[0], 12'h9C7);
        at(33); chk("t1_sv_after", 0, sample_valid[0], 0);

        // stray ack while idle
        at(34); stray[0] = 1'b1;
        at(35); stray[0] = 1'b0;

        // Y never acked on tick 44: Y req rises at 49, error visible at 57
        at(36); dly_y[0] = NEVER;
        at(46); chk("ovr_first", 1, overrun_cnt[1], 1);
        at(56); chk("t2_err_before", 0, timeout_err[0], 0);
        at(57); chk("t2_err", 0, timeout_err[0], 1);
                chk("t2_x_keep", 0, x_acc[0], 12'h9C2); chk("t2_y_keep", 0, y_acc[0], 12'h9C7);
        at(58); dly_y[0] = 2; xv[0] = 12'h5A1; yv[0] = 12'h0F3;
        at(59); chk("ch1_x", 1, x_acc[1], 12'h123); chk("ch1_y", 1, y_acc[1], 12'h456);

        // stray ack in the gap cycle before the Y request of tick 64
        at(67); stray[0] = 1'b1;
        at(68); stray[0] = 1'b0;
        at(72); chk("t2_recover_sv", 0, sample_valid[0], 1);
                chk("t2_recover_x", 0, x_acc[0], 12'h5A1); chk("t2_recover_y", 0, y_acc[0], 12'h0F3);
                chk("t2_err_sticky", 0, timeout_err[0], 1);

        // clear coinciding with an overrun on tick 84
        at(84); err_clr = 1'b1;
        at(85); err_clr = 1'b0;
        at(86); chk("clr_vs_ovr", 1, overrun_cnt[1], 1); chk("clr_err", 0, timeout_err[0], 0);
        at(95); xv[0] = 12'h7FF; yv[0] = 12'h800;
        at(99); err_clr = 1'b1;
        at(100); err_clr = 1'b0;
        at(101); chk("clr_ovr", 1, overrun_cnt[1], 0);

        // enable drops during REQ_X of tick 104; pair still publishes at 112
        at(105); enable = 1'b0;
        at(112); chk("t6_sv", 0, sample_valid[0], 1);
                 chk("t6_x", 0, x_acc[0], 12'h7FF); chk("t6_y", 0, y_acc[0], 12'h800);
        at(125); chk("t6_idle_busy", 0, busy[0], 0); chk("t6_idle_req", 0, rd_req[0], 0);

        // reset during REQ_Y of tick 159 (Y request rises at 164)
        at(140); enable = 1'b1;
        at(164); chk("t5_in_reqy", 0, rd_axis[0], 1);
        at(165); rst = 1'b1; #1;
        chk("t5_x", 0, x_acc[0], 0);        chk("t5_y", 0, y_acc[0], 0);
        chk("t5_req", 0, rd_req[0], 0);     chk("t5_busy", 0, busy[0], 0);
        chk("t5_axis", 0, rd_axis[0], 0);   chk("t5_err", 0, timeout_err[0], 0);
        chk("t5_ovr1", 1, overrun_cnt[1], 0); chk("t5_x1", 1, x_acc[1], 0);
        at(167); rst = 1'b0;
        at(193); chk("t5_sv_early", 0, sample_valid[0], 0);
        at(194); chk("t5_sv", 0, sample_valid[0], 1); chk("t5_x_after", 0, x_acc[0], 12'h7FF);

        at(225);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
